// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave memory responder backed by a word-addressed byte-strobed RAM
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int         DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // WRAP is deliberately handled as INCR; the 32-bit add wraps silently.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == BURST_FIXED)
            return addr;
        return addr + (32'd1 << size);
    endfunction

    r_state_t    r_state, r_state_next;
    logic [31:0] r_addr, r_addr_next;
    logic [3:0]  r_len, r_beat;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        ar_hs, r_hs;

    assign arready     = (r_state == R_IDLE);
    assign rvalid      = (r_state == R_DATA);
    assign rlast       = rvalid && (r_beat == r_len);
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign r_addr_next = next_addr(r_addr, r_size, r_burst);

    always_comb begin
        r_state_next = r_state;
        if (r_state == R_IDLE) begin
            if (ar_hs)
                r_state_next = R_DATA;
        end else begin
            if (r_hs && rlast)
                r_state_next = R_IDLE;
        end
    end

    // Read loads see pre-write RAM contents when a write lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                rid     <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_beat  <= '0;
                rresp   <= (arburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                rdata   <= (arburst == BURST_RSVD) ? '0 : mem[araddr[ADDR_WIDTH+1:2]];
            end else if (r_hs && !rlast) begin
                r_addr <= r_addr_next;
                r_beat <= r_beat + 4'd1;
                rdata  <= (r_burst == BURST_RSVD) ? '0 : mem[r_addr_next[ADDR_WIDTH+1:2]];
            end
        end
    end

    w_state_t    w_state, w_state_next;
    logic [31:0] w_addr, w_addr_next;
    logic [3:0]  w_len;
    logic [4:0]  w_beat;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err;
    logic        aw_hs, w_hs, b_hs;
    logic        w_in_range, w_beat_err, w_en;

    assign awready     = (w_state == W_IDLE);
    assign wready      = (w_state == W_DATA);
    assign bvalid      = (w_state == W_RESP);
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;
    assign w_addr_next = next_addr(w_addr, w_size, w_burst);
    // w_beat saturates at len+1 so surplus beats are recognised but never written.
    assign w_in_range  = (w_beat <= {1'b0, w_len});
    assign w_beat_err  = wlast ? (w_beat != {1'b0, w_len}) : !w_in_range;
    assign w_en        = w_hs && w_in_range && (w_burst != BURST_RSVD);

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)         w_state_next = W_DATA;
            W_DATA:  if (w_hs && wlast) w_state_next = W_RESP;
            W_RESP:  if (b_hs)          w_state_next = W_IDLE;
            default:                    w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                bid     <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_beat  <= '0;
                w_err   <= 1'b0;
            end else if (w_hs) begin
                w_addr <= w_addr_next;
                if (w_in_range)
                    w_beat <= w_beat + 5'd1;
                w_err <= w_err || w_beat_err;
                if (wlast)
                    bresp <= (w_err || w_beat_err || w_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[w_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wid, araddr, awaddr, r_addr, r_addr_next, w_addr, w_addr_next};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed self-checking bench for axi_sram_slave
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_data [16];
    logic [5:0]  pat;
    int          k;

    axi_sram_slave #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin @(negedge clk); n++; end
        check("w_wait", 32'(n < 50), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check({tag, "_bwait"}, 32'(n < 50), 32'd1);
        check({tag, "_bid"}, 32'(bid), 32'(id));
        check({tag, "_bresp"}, 32'(bresp), 32'(resp));
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_awready"}, 32'(awready), 32'd1);
    endtask

    task automatic write_single(input logic [31:0] addr, input logic [31:0] data);
        do_aw(4'h3, addr, 4'd0, 2'b01);
        w_beat(data, 4'hF, 1'b1);
        do_b("wr_single", 4'h3, 2'b00);
    endtask

    task automatic read_check(input string tag, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len, input logic [1:0] burst, input logic [1:0] resp);
        do_ar(id, addr, len, burst);
        for (int b = 0; b <= int'(len); b++) begin
            check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            check({tag, "_rdata"}, rdata, exp_data[b]);
            check({tag, "_rlast"}, 32'(rlast), 32'(b == int'(len)));
            check({tag, "_rresp"}, 32'(rresp), 32'(resp));
            check({tag, "_rid"}, 32'(rid), 32'(id));
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check({tag, "_rvalid_end"}, 32'(rvalid), 32'd0);
        check({tag, "_arready_end"}, 32'(arready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // preload
        write_single(32'h100, 32'hDEADBEEF);
        write_single(32'h10, 32'hAABBCCDD);
        write_single(32'h304, 32'h55555555);
        write_single(32'h504, 32'h77777777);
        do_aw(4'h2, 32'h200, 4'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'h10000080 + 32'(i), 4'hF, i == 3);
        do_b("preload_burst", 4'h2, 2'b00);

        // single read, first beat one cycle after AR handshake
        exp_data[0] = 32'hDEADBEEF;
        read_check("single", 4'h5, 32'h100, 4'd0, 2'b01, 2'b00);

        // INCR burst with rready toggling 1,0,1,1,0,1
        do_ar(4'h9, 32'h200, 4'd3, 2'b01);
        pat = 6'b101101;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            check("burst_rvalid", 32'(rvalid), 32'd1);
            check("burst_rdata", rdata, 32'h10000080 + 32'(k));
            check("burst_rlast", 32'(rlast), 32'(k == 3));
            check("burst_rid", 32'(rid), 32'h9);
            rready = pat[i];
            @(negedge clk);
            if (pat[i]) k++;
        end
        rready = 1'b0;
        check("burst_rvalid_end", 32'(rvalid), 32'd0);
        check("burst_arready_end", 32'(arready), 32'd1);

        // strobed write
        do_aw(4'hA, 32'h10, 4'd0, 2'b01);
        check("strb_wready", 32'(wready), 32'd1);
        w_beat(32'h11223344, 4'b0101, 1'b1);
        check("strb_bvalid_latency", 32'(bvalid), 32'd1);
        check("strb_wready_after", 32'(wready), 32'd0);
        do_b("strb", 4'hA, 2'b00);
        exp_data[0] = 32'hAA22CC44;
        read_check("strb_rd", 4'h1, 32'h10, 4'd0, 2'b01, 2'b00);

        // early wlast: only first word written, SLVERR
        do_aw(4'hB, 32'h300, 4'd1, 2'b01);
        w_beat(32'h12345678, 4'hF, 1'b1);
        do_b("early_wlast", 4'hB, 2'b10);
        exp_data[0] = 32'h12345678; exp_data[1] = 32'h55555555;
        read_check("early_wlast_rd", 4'h2, 32'h300, 4'd1, 2'b01, 2'b00);

        // missing wlast: surplus beat dropped, SLVERR
        do_aw(4'hC, 32'h500, 4'd0, 2'b01);
        w_beat(32'h00000001, 4'hF, 1'b0);
        w_beat(32'h00000002, 4'hF, 1'b1);
        do_b("late_wlast", 4'hC, 2'b10);
        exp_data[0] = 32'h00000001; exp_data[1] = 32'h77777777;
        read_check("late_wlast_rd", 4'h3, 32'h500, 4'd1, 2'b01, 2'b00);

        // FIXED burst: last beat wins
        do_aw(4'hD, 32'h400, 4'd2, 2'b00);
        for (int i = 0; i < 3; i++) w_beat(32'hA1 + 32'(i), 4'hF, i == 2);
        do_b("fixed", 4'hD, 2'b00);
        exp_data[0] = 32'hA3;
        read_check("fixed_rd", 4'h4, 32'h400, 4'd0, 2'b01, 2'b00);

        // reserved burst type
        exp_data[0] = 32'h0; exp_data[1] = 32'h0;
        read_check("rsvd_rd", 4'h6, 32'h100, 4'd1, 2'b11, 2'b10);
        do_aw(4'h5, 32'h100, 4'd0, 2'b11);
        w_beat(32'h0, 4'hF, 1'b1);
        do_b("rsvd_wr", 4'h5, 2'b10);
        exp_data[0] = 32'hDEADBEEF;
        read_check("rsvd_wr_rd", 4'h7, 32'h100, 4'd0, 2'b01, 2'b00);

        // concurrent read/write to same words; each read load sees pre-write data
        fork
            begin
                do_aw(4'h6, 32'h200, 4'd3, 2'b01);
                for (int i = 0; i < 4; i++) w_beat(32'hB0 + 32'(i), 4'hF, i == 3);
            end
            begin
                @(negedge clk);
                do_ar(4'h7, 32'h200, 4'd3, 2'b01);
                rready = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    check("conc_rdata_old", rdata, 32'h10000080 + 32'(b));
                    check("conc_rlast", 32'(rlast), 32'(b == 3));
                    @(negedge clk);
                end
                rready = 1'b0;
            end
        join
        do_b("conc", 4'h6, 2'b00);
        for (int i = 0; i < 4; i++) exp_data[i] = 32'hB0 + 32'(i);
        read_check("conc_rd_new", 4'h8, 32'h200, 4'd3, 2'b01, 2'b00);

        // reset during beat 2 of a len 7 read
        do_ar(4'h1, 32'h200, 4'd7, 2'b01);
        rready = 1'b1;
        @(negedge clk);
        check("rstmid_rdata_beat2", rdata, 32'hB1);
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", 32'(rvalid), 32'd0);
        check("rstmid_arready", 32'(arready), 32'd1);
        check("rstmid_rdata", rdata, 32'd0);
        @(negedge clk);
        rready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_idle_rvalid", 32'(rvalid), 32'd0);
        exp_data[0] = 32'hDEADBEEF;
        read_check("rstmid_rd", 4'h2, 32'h100, 4'd0, 2'b01, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
